// File: rtl/gate_chk_pkg.sv
// Shared types and truth-table helpers for the 2-input gate response checker.
package gate_chk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_VEC,
        ST_SETTLE,
        ST_COMPARE,
        ST_DONE
    } state_t;

    // Truth tables are indexed by {a,b}: bit 0 is a=0,b=0; bit 3 is a=1,b=1.
    localparam logic [3:0] NAND_TRUTH = 4'b0111;
    localparam logic [3:0] AND_TRUTH  = 4'b1000;
    localparam logic [3:0] OR_TRUTH   = 4'b1110;
    localparam logic [3:0] XOR_TRUTH  = 4'b0110;

    function automatic logic expected_out(input logic [3:0] truth, input logic a, input logic b);
        return truth[{a, b}];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/gate_response_checker.sv
// Receives applied (a,b) vectors over valid/ready, waits a settle window, then
// compares the gate output to a constant truth table and accumulates results.
module gate_response_checker
    import gate_chk_pkg::*;
#(
    parameter logic [3:0] TRUTH       = NAND_TRUTH,
    parameter int         NUM_VECTORS = 4,
    parameter int         SETTLE      = 2,
    parameter int         CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic             a,
    input  logic             b,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] vec_count,
    output logic             fail_seen,
    output logic [2:0]       first_fail,
    output logic [3:0]       coverage
);

    state_t     state, state_nxt;
    logic [3:0] settle_cnt;
    logic       a_lat, b_lat;
    logic       run_start, handshake, do_compare, mismatch, last_vec;

    assign run_start  = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign handshake  = vec_valid && vec_ready;
    assign do_compare = (state == ST_COMPARE);
    assign mismatch   = do_compare && (dut_out != expected_out(TRUTH, a_lat, b_lat));
    assign last_vec   = (vec_count == CNT_W'(NUM_VECTORS - 1));
    assign busy       = (state == ST_WAIT_VEC) || (state == ST_SETTLE) || (state == ST_COMPARE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: the default assignment up front keeps this block free of inferred latches.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE,
            ST_DONE:     if (start) state_nxt = ST_WAIT_VEC;
            ST_WAIT_VEC: if (handshake) state_nxt = ST_SETTLE;
            ST_SETTLE:   if (settle_cnt == 4'd0) state_nxt = ST_COMPARE;
            ST_COMPARE:  state_nxt = last_vec ? ST_DONE : ST_WAIT_VEC;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // vec_ready rises one cycle after WAIT_VEC is entered and drops on the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_ready  <= 1'b0;
            a_lat      <= 1'b0;
            b_lat      <= 1'b0;
            settle_cnt <= 4'd0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_seen  <= 1'b0;
            first_fail <= 3'b000;
            coverage   <= 4'b0000;
        end else begin
            vec_ready <= (state == ST_WAIT_VEC) && !handshake;

            if (handshake) begin
                a_lat      <= a;
                b_lat      <= b;
                settle_cnt <= 4'(SETTLE - 1);
            end else if ((state == ST_SETTLE) && (settle_cnt != 4'd0)) begin
                settle_cnt <= settle_cnt - 4'd1;
            end

            if (run_start) begin
                done       <= 1'b0;
                pass       <= 1'b0;
                fail_seen  <= 1'b0;
                first_fail <= 3'b000;
                coverage   <= 4'b0000;
            end else if (do_compare) begin
                coverage[{a_lat, b_lat}] <= 1'b1;
                if (mismatch && !fail_seen) begin
                    fail_seen  <= 1'b1;
                    first_fail <= {a_lat, b_lat, dut_out};
                end
                if (last_vec) begin
                    done <= 1'b1;
                    // Errors never decrease, so a clean run means no earlier and no current mismatch.
                    pass <= !fail_seen && !mismatch;
                end
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (run_start),
        .inc   (mismatch),
        .q     (err_count)
    );

    // Saturation is unreachable here because NUM_VECTORS stays below 2**CNT_W.
    sat_counter #(.W(CNT_W)) u_vec_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (run_start),
        .inc   (do_compare),
        .q     (vec_count)
    );

endmodule
